// File: rtl/m_multi_digit_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : m_multi_digit_counter_pkg
// Description : Shared constants for the multi-digit up/down counter slice:
//               direction encodings and the common digit terminal values.
// Revision    : 1.0 - initial release
// ============================================================================
package m_multi_digit_counter_pkg;

    // Direction encodings for up_dn
    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    // Common digit terminal values
    localparam int MAXCNT_BCD = 9;
    localparam int MAXCNT_HEX = 15;

endpackage : m_multi_digit_counter_pkg
`default_nettype wire

// File: rtl/m_multi_digit_counter_if.sv
`default_nettype none
// ============================================================================
// Module      : m_multi_digit_counter_if
// Description : Control/data bundle of the multi-digit counter. The master
//               side issues count/load/clear requests, the slave side (the
//               counter) returns the value, carry-out and overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
interface m_multi_digit_counter_if #(
    parameter int DIGITS  = 4,
    parameter int DIGIT_W = 4
);
    logic                      c_in;
    logic                      up_dn;
    logic                      clr;
    logic                      load;
    logic [DIGITS*DIGIT_W-1:0] ld_val;
    logic [DIGITS*DIGIT_W-1:0] q;
    logic                      c_out;
    logic                      ovf;

    modport master (
        output c_in, up_dn, clr, load, ld_val,
        input  q, c_out, ovf
    );

    modport slave (
        input  c_in, up_dn, clr, load, ld_val,
        output q, c_out, ovf
    );
endinterface : m_multi_digit_counter_if
`default_nettype wire

// File: rtl/m_multi_digit_counter_digit.sv
`default_nettype none
// ============================================================================
// Module      : m_updown_digit
// Description : One modulo-(MAXCNT+1) up/down counter digit with synchronous
//               clear, clamped synchronous load and a terminal-value flag for
//               the current direction.
// Revision    : 1.0 - initial release
// ============================================================================
module m_updown_digit
    import m_multi_digit_counter_pkg::*;
#(
    parameter int DIGIT_W = 4,
    parameter int MAXCNT  = 9
) (
    input  wire logic               clk,
    input  wire logic               n_reset,
    input  wire logic               en,
    input  wire logic               up_dn,
    input  wire logic               clr,
    input  wire logic               load,
    input  wire logic [DIGIT_W-1:0] ld_digit,
    output logic      [DIGIT_W-1:0] q_digit,
    output logic                    term
);

    localparam logic [DIGIT_W-1:0] C_MAX  = DIGIT_W'(MAXCNT);
    localparam logic [DIGIT_W-1:0] C_ZERO = '0;
    localparam logic [DIGIT_W-1:0] C_ONE  = DIGIT_W'(1);

    logic [DIGIT_W-1:0] r_q;
    logic [DIGIT_W-1:0] w_ld_clamped;
    logic [DIGIT_W-1:0] w_next;

    // Clamp load values so the digit can never hold anything above MAXCNT
    always_comb begin
        w_ld_clamped = (ld_digit > C_MAX) ? C_MAX : ld_digit;
    end

    // Next value of an enabled step, wrapping at both ends
    always_comb begin
        w_next = r_q;
        if (up_dn == DIR_UP) begin
            w_next = (r_q == C_MAX) ? C_ZERO : (r_q + C_ONE);
        end else begin
            w_next = (r_q == C_ZERO) ? C_MAX : (r_q - C_ONE);
        end
    end

    // Digit register: clear beats load beats count
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_q <= C_ZERO;
        end else if (clr) begin
            r_q <= C_ZERO;
        end else if (load) begin
            r_q <= w_ld_clamped;
        end else if (en) begin
            r_q <= w_next;
        end
    end

    assign q_digit = r_q;
    assign term    = (up_dn == DIR_UP) ? (r_q == C_MAX) : (r_q == C_ZERO);

endmodule : m_updown_digit
`default_nettype wire

// File: rtl/m_multi_digit_counter.sv
`default_nettype none
// ============================================================================
// Module      : m_multi_digit_counter
// Description : Cascade of DIGITS up/down counter digits. Each digit is
//               enabled in the same cycle when all lower digits sit at their
//               terminal value, so the whole counter steps in one clock.
//               Provides combinational carry/borrow-out and a sticky
//               overflow flag.
//               Optional macro MULTI_DIGIT_COUNTER_SATURATE_EN: when defined,
//               a wrapping step holds all digits instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module m_multi_digit_counter
    import m_multi_digit_counter_pkg::*;
#(
    parameter int DIGITS  = 4,
    parameter int DIGIT_W = 4,
    parameter int MAXCNT  = MAXCNT_BCD
) (
    input  wire logic               clk,
    input  wire logic               n_reset,
    m_multi_digit_counter_if.slave  bus
);

    logic [DIGITS-1:0]         w_term;
    logic [DIGITS-1:0]         w_en;
    logic [DIGITS:0]           w_prefix;
    logic [DIGITS*DIGIT_W-1:0] w_q;
    logic                      w_step;
    logic                      w_all_term;
    logic                      w_c_out;
    logic                      w_sat_hold;
    logic                      r_ovf;

    // A count step is requested only when neither clear nor load take priority
    assign w_step = bus.c_in & ~bus.clr & ~bus.load;

    // Lookahead chain: bit i is set when every digit below i is terminal
    always_comb begin
        w_prefix[0] = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            w_prefix[i+1] = w_prefix[i] & w_term[i];
        end
    end

    assign w_all_term = w_prefix[DIGITS];
    assign w_c_out    = w_step & w_all_term;

`ifdef MULTI_DIGIT_COUNTER_SATURATE_EN
    // Saturating build: a wrapping step freezes every digit
    assign w_sat_hold = w_c_out;
`else
    assign w_sat_hold = 1'b0;
`endif

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign w_en[gi] = w_step & w_prefix[gi] & ~w_sat_hold;

            m_updown_digit #(
                .DIGIT_W (DIGIT_W),
                .MAXCNT  (MAXCNT)
            ) u_digit (
                .clk      (clk),
                .n_reset  (n_reset),
                .en       (w_en[gi]),
                .up_dn    (bus.up_dn),
                .clr      (bus.clr),
                .load     (bus.load),
                .ld_digit (bus.ld_val[gi*DIGIT_W +: DIGIT_W]),
                .q_digit  (w_q[gi*DIGIT_W +: DIGIT_W]),
                .term     (w_term[gi])
            );
        end
    endgenerate

    // Sticky overflow: set on any wrapping step, dropped by clear or load
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_ovf <= 1'b0;
        end else if (bus.clr || bus.load) begin
            r_ovf <= 1'b0;
        end else if (w_c_out) begin
            r_ovf <= 1'b1;
        end
    end

    assign bus.q     = w_q;
    assign bus.c_out = w_c_out;
    assign bus.ovf   = r_ovf;

endmodule : m_multi_digit_counter
`default_nettype wire

// File: tb/tb_m_multi_digit_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_m_multi_digit_counter
// Description : Directed self-checking bench for the 4-digit BCD counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_m_multi_digit_counter;

    logic clk;
    logic n_reset;
    int   n_checks;
    int   n_pass;
    logic saw_cout;

    m_multi_digit_counter_if #(.DIGITS(4), .DIGIT_W(4)) bus ();

    m_multi_digit_counter #(
        .DIGITS  (4),
        .DIGIT_W (4),
        .MAXCNT  (9)
    ) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply inputs just after a falling edge and let combinational logic settle
    task automatic drive(input logic c_in, input logic up_dn, input logic clr,
                         input logic load, input logic [15:0] ld_val);
        bus.c_in   = c_in;
        bus.up_dn  = up_dn;
        bus.clr    = clr;
        bus.load   = load;
        bus.ld_val = ld_val;
        #1;
    endtask

    // Let one rising edge pass, return at the following falling edge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        saw_cout = 1'b0;
        n_reset  = 1'b0;
        bus.c_in = 1'b0; bus.up_dn = 1'b1; bus.clr = 1'b0; bus.load = 1'b0; bus.ld_val = '0;

        // Reset state
        #12;
        check("reset_q", bus.q, 32'h0000);
        check("reset_ovf", bus.ovf, 0);
        @(negedge clk);
        n_reset = 1'b1;

        // Ten single-cycle up pulses
        for (int i = 0; i < 10; i++) begin
            drive(1, 1, 0, 0, 16'h0000);
            saw_cout = saw_cout | bus.c_out;
            tick();
            drive(0, 1, 0, 0, 16'h0000);
            tick();
        end
        check("ten_up_q", bus.q, 32'h0010);
        check("ten_up_cout_seen", saw_cout, 0);
        check("ten_up_ovf", bus.ovf, 0);

        // Hold with c_in low
        tick();
        check("hold_q", bus.q, 32'h0010);

        // Load 0999 then one up step ripples to 1000 in a single clock
        drive(0, 1, 0, 1, 16'h0999);
        tick();
        check("load_0999_q", bus.q, 32'h0999);
        drive(1, 1, 0, 0, 16'h0000);
        check("step_0999_cout", bus.c_out, 0);
        tick();
        check("step_0999_q", bus.q, 32'h1000);

        // Borrow across digits: 1000 down -> 0999
        drive(1, 0, 0, 0, 16'h0000);
        check("down_1000_cout", bus.c_out, 0);
        tick();
        check("down_1000_q", bus.q, 32'h0999);

        // Up wrap from 9999
        drive(0, 1, 0, 1, 16'h9999);
        tick();
        check("load_9999_q", bus.q, 32'h9999);
        drive(1, 1, 0, 0, 16'h0000);
        check("wrap_up_cout", bus.c_out, 1);
        tick();
`ifdef MULTI_DIGIT_COUNTER_SATURATE_EN
        check("wrap_up_q", bus.q, 32'h9999);
`else
        check("wrap_up_q", bus.q, 32'h0000);
`endif
        check("wrap_up_ovf", bus.ovf, 1);

        // Clear drops ovf
        drive(0, 1, 1, 0, 16'h0000);
        tick();
        check("clr_ovf", bus.ovf, 0);
        check("clr_q", bus.q, 32'h0000);

        // Down wrap from 0000, then one more down step
        drive(1, 0, 0, 0, 16'h0000);
        check("wrap_dn_cout", bus.c_out, 1);
        tick();
        check("wrap_dn_ovf", bus.ovf, 1);
`ifdef MULTI_DIGIT_COUNTER_SATURATE_EN
        check("wrap_dn_q", bus.q, 32'h0000);
        check("dn_again_cout", bus.c_out, 1);
        tick();
        check("dn_again_q", bus.q, 32'h0000);
`else
        check("wrap_dn_q", bus.q, 32'h9999);
        check("dn_again_cout", bus.c_out, 0);
        tick();
        check("dn_again_q", bus.q, 32'h9998);
`endif
        check("dn_again_ovf", bus.ovf, 1);

        // Load clamps per digit and clears ovf
        drive(0, 1, 0, 1, 16'hFA37);
        tick();
        check("clamp_q", bus.q, 32'h9937);
        check("clamp_ovf", bus.ovf, 0);

        // clr beats load and count in the same cycle
        drive(1, 1, 1, 1, 16'h5555);
        check("prio_cout", bus.c_out, 0);
        tick();
        check("prio_q", bus.q, 32'h0000);

        // Three up steps starting at 9999
        drive(0, 1, 0, 1, 16'h9999);
        tick();
        drive(1, 1, 0, 0, 16'h0000);
        check("three_c1_cout", bus.c_out, 1);
        tick();
`ifdef MULTI_DIGIT_COUNTER_SATURATE_EN
        check("three_c2_cout", bus.c_out, 1);
        tick();
        check("three_c3_cout", bus.c_out, 1);
        tick();
        check("three_q", bus.q, 32'h9999);
`else
        check("three_c2_cout", bus.c_out, 0);
        tick();
        check("three_c3_cout", bus.c_out, 0);
        tick();
        check("three_q", bus.q, 32'h0002);
`endif
        check("three_ovf", bus.ovf, 1);

        // Asynchronous reset between edges while still counting
        #2;
        n_reset = 1'b0;
        #1;
        check("async_rst_q", bus.q, 32'h0000);
        check("async_rst_ovf", bus.ovf, 0);
        @(negedge clk);
        drive(0, 1, 0, 0, 16'h0000);
        n_reset = 1'b1;
        tick();
        check("post_rst_q", bus.q, 32'h0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Hard time limit so the run can never hang
    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule : tb_m_multi_digit_counter
`default_nettype wire

// File: doc/m_multi_digit_counter.md
Name: m_multi_digit_counter

Overview:
Parametrised cascade of DIGITS modulo-(MAXCNT+1) up/down counter digits with single-cycle carry/borrow lookahead.
Adds direction control, synchronous load and clear, per-digit load clamping, a chained carry-out and a sticky overflow flag.
Drives multi-digit seven-segment displays, stopwatches and event counters. Each q digit feeds one segment decoder.

Parameters:
DIGITS, 4, number of cascaded digits (>=1)
DIGIT_W, 4, bits per digit; 2**DIGIT_W must exceed MAXCNT
MAXCNT, 9, terminal value of every digit (>=1); 9 = BCD, 15 = hex

Ports:
clk  in  1  system clock, rising edge
n_reset  in  1  asynchronous active-low reset
c_in  in  1  count enable for this cycle (one step)
up_dn  in  1  direction: 1 = up, 0 = down; sampled every cycle
clr  in  1  synchronous clear
load  in  1  synchronous parallel load
ld_val  in  DIGITS*DIGIT_W  load value; digit i at [i*DIGIT_W +: DIGIT_W]
q  out  DIGITS*DIGIT_W  counter value, digit 0 least significant
c_out  out  1  combinational carry/borrow: the current step wraps the whole counter
ovf  out  1  registered sticky overflow/underflow flag

Behaviour:
- Clock and reset: one clock, clk. Reset n_reset is asynchronous, active-low. While n_reset=0: q=0 and ovf=0 immediately.
- Priority per rising edge: clr > load > count. Otherwise hold.
- clr: all digits go to 0 and ovf goes to 0. load and c_in are ignored that cycle.
- load: digit i = ld_val digit i. Any digit value greater than MAXCNT is clamped to MAXCNT. ovf goes to 0. c_in is ignored.
- Digit terminal value: MAXCNT when up_dn=1; 0 when up_dn=0.
- Digit i enable (combinational): c_in & !clr & !load & (every digit j<i is at its terminal value). Digit 0 enable is c_in & !clr & !load.
- Enabled digit counting up: MAXCNT -> 0, else +1.
- Enabled digit counting down: 0 -> MAXCNT, else -1.
- Whole counter steps exactly once per enabled cycle. Latency is 1 clock from c_in to q. No multi-cycle ripple.
- c_out = c_in & !clr & !load & (all digits at terminal value for the current up_dn). It is combinational and asserts in the same cycle as the wrapping edge.
- ovf is set on any edge where c_out=1. It stays set until clr, load or reset.
- up_dn may change on any cycle. The new direction applies to that cycle's step and to that cycle's c_out.
- Out-of-range digits (>MAXCNT) can be reached only through load, and load clamps them, so no digit ever holds a value above MAXCNT.
- Arithmetic is modulo per digit. There is no binary carry between digits other than the enable chain.

Optional Feature:
Macro: MULTI_DIGIT_COUNTER_SATURATE_EN
- Defined: on an edge where c_out=1, all digits hold instead of wrapping (9999 stays 9999 up; 0000 stays 0000 down). c_out and ovf behave as in the base mode.
- Undefined: wrap-around exactly as in Behaviour.

Decomposition:
- Shared header counter_defs.vh: DIR_UP=1'b1, DIR_DN=1'b0, MAXCNT_BCD=9, MAXCNT_HEX=15.
- Sub-module m_updown_digit, parameters DIGIT_W and MAXCNT.
  - Inputs: clk, n_reset, en, up_dn, clr, load, ld_digit.
  - Outputs: q_digit, and term (digit at terminal value for the current up_dn).
  - It clamps load values internally.
- Top level: generate loop over digits, AND-chain of term signals, c_out logic and the ovf register.

Test Plan:
All scenarios use DIGITS=4, MAXCNT=9.
- Reset, up_dn=1, 10 single-cycle c_in pulses -> q=16'h0010, c_out never 1, ovf=0.
- load 16'h0999, then one c_in up -> q=16'h1000 one clock later, c_out=0.
- load 16'h9999, c_in up -> c_out=1 in that cycle, q=16'h0000, ovf=1. Then clr -> ovf=0.
- From 16'h0000 with up_dn=0, c_in -> c_out=1, q=16'h9999, ovf=1. Next down step -> q=16'h9998.
- Clamp and priority:
  - load with ld_val=16'hFA37 -> q=16'h9937.
  - clr=1 and load=1 with c_in=1 in the same cycle -> q=16'h0000.
  - n_reset pulled low between edges mid-count -> q=0 and ovf=0 without waiting for a clock edge.
- With MULTI_DIGIT_COUNTER_SATURATE_EN defined:
  - At 16'h9999, c_in up for 3 cycles -> q stays 16'h9999, c_out=1 each cycle, ovf=1.
  - Without the macro, the same stimulus -> q=16'h0002.
